// File: rtl/vga_display_adapter.sv
// VGA display adapter: 640x480@60 timing from gpu_clk, 2x-doubled reads from a 320x240x4 frame
// buffer, 4-bit index to 12-bit RGB. Define VGA_PALETTE_EN for the CGA palette, else grayscale.
module vga_display_adapter #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_WIDTH = 320
) (
  input  logic        gpu_clk,
  input  logic        rst,
  output logic [16:0] vga_pixel_addr,
  input  logic [3:0]  vga_pixel_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Flag bundle order in the delay line: {active, hs_n, vs_n, fs}
  localparam logic [3:0] FLAGS_IDLE = 4'b0110;

  logic [DIV_W-1:0] div_cnt_r;
  logic [9:0]       h_r;
  logic [9:0]       v_r;
  logic             tick_s;
  logic             h_last_s;
  logic             v_last_s;
  logic             active_s;
  logic             hs_n_s;
  logic             vs_n_s;
  logic             fs_s;
  logic [16:0]      y_ext_s;
  logic [16:0]      x_ext_s;
  logic [16:0]      addr_s;
  logic [3:0]       flags_d1_r;
  logic [3:0]       flags_d2_r;
  logic [11:0]      rgb_s;

  function automatic logic [11:0] map_color(input logic [3:0] idx);
`ifdef VGA_PALETTE_EN
    logic [11:0] rgb;
    case (idx)
      4'h0:    rgb = 12'h000;
      4'h1:    rgb = 12'h00A;
      4'h2:    rgb = 12'h0A0;
      4'h3:    rgb = 12'h0AA;
      4'h4:    rgb = 12'hA00;
      4'h5:    rgb = 12'hA0A;
      4'h6:    rgb = 12'hA50;
      4'h7:    rgb = 12'hAAA;
      4'h8:    rgb = 12'h555;
      4'h9:    rgb = 12'h55F;
      4'hA:    rgb = 12'h5F5;
      4'hB:    rgb = 12'h5FF;
      4'hC:    rgb = 12'hF55;
      4'hD:    rgb = 12'hF5F;
      4'hE:    rgb = 12'hFF5;
      4'hF:    rgb = 12'hFFF;
      default: rgb = 12'h000;
    endcase
    return rgb;
`else
    return {idx, idx, idx};
`endif
  endfunction

  assign tick_s   = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign h_last_s = (h_r == 10'(H_TOTAL - 1));
  assign v_last_s = (v_r == 10'(V_TOTAL - 1));

  // Pixel-tick divider and raster counters; the whole frame wraps on a single tick
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      div_cnt_r <= DIV_W'(0);
      h_r       <= 10'd0;
      v_r       <= 10'd0;
    end else if (tick_s) begin
      div_cnt_r <= DIV_W'(0);
      if (h_last_s) begin
        h_r <= 10'd0;
        v_r <= v_last_s ? 10'd0 : v_r + 10'd1;
      end else begin
        h_r <= h_r + 10'd1;
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  assign active_s = (h_r < 10'(H_ACTIVE)) && (v_r < 10'(V_ACTIVE));
  assign hs_n_s   = !((h_r >= 10'(H_ACTIVE + H_FP)) && (h_r < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n_s   = !((v_r >= 10'(V_ACTIVE + V_FP)) && (v_r < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign fs_s     = (h_r == 10'd0) && (v_r == 10'd0) && (div_cnt_r == DIV_W'(0));
  assign y_ext_s  = {8'd0, v_r[9:1]};
  assign x_ext_s  = {8'd0, h_r[9:1]};

  // Doubled source address; the default 320 stride avoids a multiplier
  always_comb begin
    addr_s = 17'd0;
    if (active_s) begin
      if (FB_WIDTH == 320) begin
        addr_s = (y_ext_s << 8) + (y_ext_s << 6) + x_ext_s;
      end else begin
        addr_s = (y_ext_s * 17'(FB_WIDTH)) + x_ext_s;
      end
    end else begin
      addr_s = 17'd0;
    end
  end

  always_comb begin
    rgb_s = 12'd0;
    if (flags_d2_r[3]) begin
      rgb_s = map_color(vga_pixel_data);
    end else begin
      rgb_s = 12'd0;
    end
  end

  // Three-stage pipeline: address, frame buffer read, colour/sync output
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      vga_pixel_addr  <= 17'd0;
      flags_d1_r      <= FLAGS_IDLE;
      flags_d2_r      <= FLAGS_IDLE;
      vga_hsync       <= 1'b1;
      vga_vsync       <= 1'b1;
      vga_frame_start <= 1'b0;
      vga_r           <= 4'd0;
      vga_g           <= 4'd0;
      vga_b           <= 4'd0;
    end else begin
      vga_pixel_addr  <= addr_s;
      flags_d1_r      <= {active_s, hs_n_s, vs_n_s, fs_s};
      flags_d2_r      <= flags_d1_r;
      vga_hsync       <= flags_d2_r[2];
      vga_vsync       <= flags_d2_r[1];
      vga_frame_start <= flags_d2_r[0];
      vga_r           <= rgb_s[11:8];
      vga_g           <= rgb_s[7:4];
      vga_b           <= rgb_s[3:0];
    end
  end

endmodule
